// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and saturating-counter helpers for the branch target buffer
package bp_pkg;

  localparam int CTR_MAX_W = 4;
  localparam int BP_CTR_W  = 2;

  // Widest counter any instance may use; narrower counters zero-extend into it.
  typedef logic [CTR_MAX_W-1:0] ctr_ext_t;

  function automatic ctr_ext_t ctr_weak_t(input int ctr_w);
    return CTR_MAX_W'(1 << (ctr_w - 1));
  endfunction

  function automatic ctr_ext_t ctr_weak_nt(input int ctr_w);
    return CTR_MAX_W'((1 << (ctr_w - 1)) - 1);
  endfunction

  localparam ctr_ext_t CTR_WEAK_T  = ctr_weak_t(BP_CTR_W);
  localparam ctr_ext_t CTR_WEAK_NT = ctr_weak_nt(BP_CTR_W);

  function automatic ctr_ext_t ctr_sat_next(input ctr_ext_t ctr, input logic taken,
                                            input int ctr_w);
    ctr_ext_t max_v;
    max_v = CTR_MAX_W'((1 << ctr_w) - 1);
    if (taken)
      return (ctr >= max_v) ? max_v : ctr + CTR_MAX_W'(1);
    else
      return (ctr == '0) ? '0 : ctr - CTR_MAX_W'(1);
  endfunction

  // Entry layout at the default 16-bit address / 2-bit counter geometry.
  typedef struct packed {
    logic                valid;
    logic [15:0]         tag;
    logic [15:0]         target;
    logic [BP_CTR_W-1:0] ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - CTR_W-wide saturating up/down direction counter with parallel load
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             step,
  input  logic             up,
  output logic [CTR_W-1:0] ctr
);

  logic [CTR_W-1:0] ctr_nxt;

  assign ctr_nxt = CTR_W'(ctr_sat_next(CTR_MAX_W'(ctr), up, CTR_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ctr <= '0;
    else if (load)
      ctr <= load_val;
    else if (step)
      ctr <= ctr_nxt;
  end

endmodule

// File: rtl/bp_btb_param.sv
// rtl/bp_btb_param.sv - parametrised BTB with saturating direction counters; BP_PERF_CNT_EN adds perf counters
module bp_btb_param
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 8,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic [ADDR_W-1:0] ex_pc_plus,
  input  logic              ex_taken,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  input  logic              bp_clear,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
`endif
);

  localparam int               RP_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [RP_W-1:0]  RP_LAST = RP_W'(ENTRIES - 1);
  localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
  localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));

  logic              valid  [ENTRIES];
  logic [ADDR_W-1:0] tag    [ENTRIES];
  logic [ADDR_W-1:0] target [ENTRIES];
  logic [CTR_W-1:0]  ctr    [ENTRIES];
  logic [RP_W-1:0]   rp;

  logic            lk_hit, ex_hit;
  logic [RP_W-1:0] lk_idx, ex_idx;
  logic            upd, alloc;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    ex_hit = 1'b0;
    ex_idx = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (valid[k] && tag[k] == if_pc) begin
        lk_hit = 1'b1;
        lk_idx = RP_W'(k);
      end
      if (valid[k] && tag[k] == ex_pc) begin
        ex_hit = 1'b1;
        ex_idx = RP_W'(k);
      end
    end
  end

  assign pred_taken  = lk_hit & ctr[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? target[lk_idx] : '0;

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (ex_valid) begin
      if (ex_taken && (!ex_pred_taken || ex_pred_target != ex_target)) begin
        redirect    = 1'b1;
        redirect_pc = ex_target;
      end else if (!ex_taken && ex_pred_taken) begin
        redirect    = 1'b1;
        redirect_pc = ex_pc_plus;
      end
    end
  end

  assign upd   = ex_valid & ~bp_clear;
  assign alloc = upd & ~ex_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        valid[k]  <= 1'b0;
        tag[k]    <= '0;
        target[k] <= '0;
      end
      rp <= '0;
    end else if (bp_clear) begin
      for (int k = 0; k < ENTRIES; k++) valid[k] <= 1'b0;
      rp <= '0;
    end else if (ex_valid) begin
      if (ex_hit) begin
        if (ex_taken) target[ex_idx] <= ex_target;
      end else begin
        valid[rp]  <= 1'b1;
        tag[rp]    <= ex_pc;
        target[rp] <= ex_target;
        rp         <= (rp == RP_LAST) ? '0 : rp + RP_W'(1);
      end
    end
  end

  for (genvar k = 0; k < ENTRIES; k++) begin : g_ctr
    bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (alloc && (rp == RP_W'(k))),
      .load_val (ex_taken ? WEAK_T : WEAK_NT),
      .step     (upd && ex_hit && (ex_idx == RP_W'(k))),
      .up       (ex_taken),
      .ctr      (ctr[k])
    );
  end

`ifdef BP_PERF_CNT_EN
  // Deliberately untouched by bp_clear so software sees totals across flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (ex_valid) perf_branches    <= perf_branches + 32'd1;
      if (redirect) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_btb_param.sv
// tb/tb_bp_btb_param.sv - self-checking bench for bp_btb_param against a behavioural BTB model
module tb_bp_btb_param;

  localparam int AW = 16;
  localparam int NE = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] if_pc = '0;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          ex_valid = 1'b0;
  logic [AW-1:0] ex_pc = '0;
  logic [AW-1:0] ex_target = '0;
  logic [AW-1:0] ex_pc_plus = '0;
  logic          ex_taken = 1'b0;
  logic          ex_pred_taken = 1'b0;
  logic [AW-1:0] ex_pred_target = '0;
  logic          bp_clear = 1'b0;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
  logic [31:0]   perf_branches;
  logic [31:0]   perf_mispredicts;
`endif

  always #5 clk = ~clk;

  bp_btb_param #(.ADDR_W(AW), .ENTRIES(NE), .CTR_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pc_plus     (ex_pc_plus),
    .ex_taken       (ex_taken),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .bp_clear       (bp_clear),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a table of entries, counters as plain integers.
  bit            m_valid [NE];
  logic [AW-1:0] m_tag   [NE];
  logic [AW-1:0] m_tgt   [NE];
  int            m_ctr   [NE];
  int            m_rp;
  logic [31:0]   m_br, m_mis;
  int            mk;

  function automatic int m_find(input logic [AW-1:0] pc);
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  function automatic logic m_redirect();
    if (!ex_valid) return 1'b0;
    if (ex_taken) return !ex_pred_taken || (ex_pred_target != ex_target);
    return ex_pred_taken;
  endfunction

  function automatic logic [AW-1:0] m_redirect_pc();
    if (!m_redirect()) return '0;
    return ex_taken ? ex_target : ex_pc_plus;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 0;
    end
    m_rp  = 0;
    m_br  = '0;
    m_mis = '0;
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      if (ex_valid) m_br = m_br + 32'd1;
      if (m_redirect()) m_mis = m_mis + 32'd1;
      if (bp_clear) begin
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
        m_rp = 0;
      end else if (ex_valid) begin
        mk = m_find(ex_pc);
        if (mk >= 0) begin
          if (ex_taken) begin
            if (m_ctr[mk] < (1 << CW) - 1) m_ctr[mk] = m_ctr[mk] + 1;
            m_tgt[mk] = ex_target;
          end else if (m_ctr[mk] > 0) begin
            m_ctr[mk] = m_ctr[mk] - 1;
          end
        end else begin
          m_valid[m_rp] = 1'b1;
          m_tag[m_rp]   = ex_pc;
          m_tgt[m_rp]   = ex_target;
          m_ctr[m_rp]   = ex_taken ? (1 << (CW - 1)) : (1 << (CW - 1)) - 1;
          m_rp          = (m_rp + 1) % NE;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int            k;
    logic          ept;
    logic [AW-1:0] eptg;
    k    = m_find(if_pc);
    ept  = (k >= 0) && (m_ctr[k] >= (1 << (CW - 1)));
    eptg = '0;
    if (ept) eptg = m_tgt[k];
    check("mdl_pred_taken", 32'(pred_taken), 32'(ept));
    check("mdl_pred_target", 32'(pred_target), 32'(eptg));
    check("mdl_redirect", 32'(redirect), 32'(m_redirect()));
    check("mdl_redirect_pc", 32'(redirect_pc), 32'(m_redirect_pc()));
`ifdef BP_PERF_CNT_EN
    check("mdl_perf_branches", perf_branches, m_br);
    check("mdl_perf_mispredicts", perf_mispredicts, m_mis);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [AW-1:0] pc, input logic tk,
                        input logic [AW-1:0] tgt, input logic pt, input logic [AW-1:0] ptt);
    ex_valid       = v;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pc_plus     = pc + 16'd1;
    ex_pred_taken  = pt;
    ex_pred_target = ptt;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    bp_clear = 1'b0;
  endtask

  task automatic look(input string name, input logic [AW-1:0] pc, input logic et,
                      input logic [AW-1:0] etg);
    if_pc = pc;
    #1;
    check({name, "_taken"}, 32'(pred_taken), 32'(et));
    check({name, "_target"}, 32'(pred_target), 32'(etg));
  endtask

  initial begin
    if_pc = 16'h0010;
    #2;
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_pred_target", 32'(pred_target), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    #1;
    rst = 1'b1;

    set_ex(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
    #1;
    check("first_redirect", 32'(redirect), 32'd1);
    check("first_redirect_pc", 32'(redirect_pc), 32'h40);
    check("first_no_bypass", 32'(pred_taken), 32'd0);
    tick();

    set_ex(1'b1, 16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    look("alloc", 16'h0010, 1'b1, 16'h0040);
    check("nt_redirect", 32'(redirect), 32'd1);
    check("nt_redirect_pc", 32'(redirect_pc), 32'h11);
    tick();
    idle();
    look("weak_nt", 16'h0010, 1'b0, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      set_ex(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
      tick();
    end
    idle();
    look("sat_hi", 16'h0010, 1'b1, 16'h0040);
    set_ex(1'b1, 16'h0010, 1'b0, 16'h0040, 1'b0, 16'h0000);
    tick();
    idle();
    look("sat_hi_m1", 16'h0010, 1'b1, 16'h0040);
    for (int i = 0; i < 5; i++) begin
      set_ex(1'b1, 16'h0010, 1'b0, 16'h0040, 1'b0, 16'h0000);
      tick();
    end
    idle();
    look("sat_lo", 16'h0010, 1'b0, 16'h0000);
    set_ex(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
    tick();
    idle();
    look("no_underflow", 16'h0010, 1'b0, 16'h0000);
    set_ex(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
    tick();
    idle();
    look("recover", 16'h0010, 1'b1, 16'h0040);

    set_ex(1'b1, 16'h0010, 1'b1, 16'h0080, 1'b1, 16'h0040);
    #1;
    check("tgt_mis_redirect", 32'(redirect), 32'd1);
    check("tgt_mis_redirect_pc", 32'(redirect_pc), 32'h80);
    tick();
    idle();
    look("tgt_updated", 16'h0010, 1'b1, 16'h0080);

    bp_clear = 1'b1;
    tick();
    bp_clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_ex(1'b1, 16'(16'h0100 + i), 1'b1, 16'(16'h0200 + i), 1'b0, 16'h0000);
      tick();
    end
    idle();
    look("wrap_evicted", 16'h0100, 1'b0, 16'h0000);
    look("wrap_newest", 16'h0105, 1'b1, 16'h0205);
    look("wrap_kept", 16'h0101, 1'b1, 16'h0201);
    set_ex(1'b1, 16'h0106, 1'b1, 16'h0206, 1'b0, 16'h0000);
    tick();
    idle();
    look("rp_next_evict", 16'h0101, 1'b0, 16'h0000);
    look("rp_next_kept", 16'h0102, 1'b1, 16'h0202);

    set_ex(1'b1, 16'h0300, 1'b1, 16'h0500, 1'b0, 16'h0000);
    bp_clear = 1'b1;
    #1;
    check("clr_redirect", 32'(redirect), 32'd1);
    check("clr_redirect_pc", 32'(redirect_pc), 32'h500);
    tick();
    idle();
    look("clr_dropped", 16'h0300, 1'b0, 16'h0000);
    look("clr_invalid", 16'h0102, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      set_ex(1'b1, 16'(16'h0400 + i), 1'b1, 16'(16'h0600 + i), 1'b0, 16'h0000);
      tick();
    end
    idle();
    look("clr_rp0_evict", 16'h0400, 1'b0, 16'h0000);
    look("clr_rp0_kept", 16'h0401, 1'b1, 16'h0601);

    look("pre_rst_hit", 16'h0405, 1'b1, 16'h0605);
    rst = 1'b0;
    #1;
    check("async_rst_taken", 32'(pred_taken), 32'd0);
    check("async_rst_target", 32'(pred_target), 32'd0);
    check("async_rst_redirect", 32'(redirect), 32'd0);
    rst = 1'b1;
    look("post_rst_miss", 16'h0405, 1'b0, 16'h0000);

    for (int n = 0; n < 3000; n++) begin
      tick();
      ex_valid       = ($urandom_range(0, 9) < 6);
      ex_pc          = 16'(16'h0100 + $urandom_range(0, 11));
      ex_pc_plus     = ex_pc + 16'd1;
      ex_taken       = 1'($urandom_range(0, 1));
      ex_target      = 16'(16'h0200 + $urandom_range(0, 3));
      ex_pred_taken  = 1'($urandom_range(0, 1));
      ex_pred_target = 16'(16'h0200 + $urandom_range(0, 3));
      bp_clear       = ($urandom_range(0, 49) == 0);
      if_pc          = 16'(16'h0100 + $urandom_range(0, 11));
      rst            = !($urandom_range(0, 299) == 0);
    end
    tick();
    rst = 1'b1;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_btb_param.md
Name: bp_btb_param

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters.
- Replaces the fixed 5-entry, 16-bit, 2-bit-history predictor.
- Sits beside the PC register: the IF stage looks up predictions combinationally, and the EX stage writes back resolved branch outcomes on the clock edge.
- Adds over the fixed version: valid bits, configurable depth, address width and counter width; wrap-safe round-robin replacement; bulk clear; fully defined (non-X) outputs.

Parameters:
- ADDR_W, 16, PC/target address width in bits.
- ENTRIES, 8, number of BTB entries; 2..64, power of two not required.
- CTR_W, 2, saturating direction counter width; 1..4. Predict taken when counter MSB = 1.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- if_pc  in  ADDR_W  PC currently in PC register (lookup key)
- pred_taken  out  1  lookup hit and counter MSB = 1
- pred_target  out  ADDR_W  stored target on predicted-taken hit, else 0
- ex_valid  in  1  a conditional branch resolves in EX this cycle
- ex_pc  in  ADDR_W  PC of resolving branch
- ex_target  in  ADDR_W  computed branch target
- ex_pc_plus  in  ADDR_W  fall-through address of resolving branch
- ex_taken  in  1  actual outcome (1 = taken)
- ex_pred_taken  in  1  prediction that travelled down the pipe with this branch
- ex_pred_target  in  ADDR_W  predicted target that travelled with it
- bp_clear  in  1  invalidate all entries next edge
- redirect  out  1  mispredict; flush younger stages and load redirect_pc
- redirect_pc  out  ADDR_W  corrected PC when redirect=1, else 0

Behaviour:
- State per entry: valid, tag[ADDR_W], target[ADDR_W], ctr[CTR_W]. Global state: replacement pointer rp, range 0..ENTRIES-1.
- Reset (rst=0, async): all valid=0, tags/targets/ctrs=0, rp=0. Outputs follow combinationally: pred_taken=0, pred_target=0; redirect=0, redirect_pc=0 while ex_valid=0.
- Lookup (combinational, zero latency):
  - hit = some valid entry with tag == if_pc; on multiple matches the lowest index wins.
  - pred_taken = hit & ctr[CTR_W-1]; pred_target = pred_taken ? target : 0.
  - Lookup reads pre-edge state; an update in the same cycle is not bypassed.
- Redirect (combinational, only when ex_valid=1):
  - ex_taken=1 and (ex_pred_taken=0 or ex_pred_target != ex_target): redirect=1, redirect_pc=ex_target.
  - ex_taken=0 and ex_pred_taken=1: redirect=1, redirect_pc=ex_pc_plus.
  - Otherwise redirect=0.
- Update (rising edge, ex_valid=1, bp_clear=0):
  - Hit on ex_pc at entry k:
    - ctr saturating +1 if taken, saturating -1 if not taken; no wrap at 0 or 2^CTR_W-1.
    - target <= ex_target only if taken; a not-taken update keeps the old target.
  - Miss:
    - Allocate entry rp: valid=1, tag=ex_pc, target=ex_target.
    - ctr = 2^(CTR_W-1) (weak taken) if taken, else 2^(CTR_W-1)-1 (weak not-taken).
    - rp <= (rp == ENTRIES-1) ? 0 : rp+1.
    - Replacement is round-robin regardless of valid bits.
- bp_clear=1: all valid<=0 and rp<=0 on the edge. Clear wins over a simultaneous update (update dropped). Redirect output is unaffected.
- ex_valid=0: no state change. Counters never change on lookup alone.
- Same PC looked up and updated in one cycle: lookup returns old state; the new state is visible the next cycle.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_branches[31:0] and perf_mispredicts[31:0], both reset to 0.
  - perf_branches increments on every ex_valid=1 edge; perf_mispredicts increments when redirect=1.
  - Both wrap modulo 2^32. bp_clear does not reset them.
- Undefined: ports and counters absent, no extra logic.

Decomposition:
- Package bp_pkg:
  - function ctr_sat_next(ctr, taken, CTR_W).
  - localparams CTR_WEAK_T / CTR_WEAK_NT derived from CTR_W.
  - Entry struct typedef (valid, tag, target, ctr).
- One sub-module: bp_sat_ctr (CTR_W-wide saturating up/down counter with load), instantiated per entry.
- Tag compare and priority encode stay in the top module.

Test Plan:
- Reset then if_pc=0x0010, no updates -> pred_taken=0, pred_target=0; ex_valid=1, ex_taken=1, ex_pred_taken=0, ex_target=0x0040 -> redirect=1, redirect_pc=0x0040.
- Allocate: ex_pc=0x0010 taken to 0x0040 (CTR_W=2) -> next cycle if_pc=0x0010 gives pred_taken=1, pred_target=0x0040. Then resolve not-taken with ex_pred_taken=1, ex_pc_plus=0x0011 -> redirect=1, redirect_pc=0x0011; ctr=01, so the next lookup gives pred_taken=0.
- Saturation: 5 taken updates on one entry -> ctr=11; one not-taken -> 10, still predicts taken. 5 not-taken -> 00, no underflow.
- Replacement wrap with ENTRIES=5: allocate PCs 0x100..0x105 (6 misses) -> 0x100 evicted (lookup miss), 0x105 held in entry 0, rp=1.
- Target mismatch: entry predicts 0x0040, branch resolves taken to 0x0080 with ex_pred_taken=1, ex_pred_target=0x0040 -> redirect=1, redirect_pc=0x0080; next lookup returns target 0x0080.
- bp_clear asserted in the same cycle as an ex_valid allocation -> all lookups miss, rp=0. Separately, assert rst=0 mid-stream -> outputs go 0 immediately without a clock edge. With BP_PERF_CNT_EN, counters are checked against scoreboard totals.
